// File: rtl/rtc_multi_alarm_core.sv
// 24-hour real-time clock with NUM_ALARMS alarm slots and a ring/snooze/dismiss controller.
// Define RTC_HOUR12_EN to present hh as 1..12 with an added pm output.
module rtc_multi_alarm_core #(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int NUM_ALARMS    = 4,
  parameter int SNOOZE_MIN    = 5,
  parameter int RING_SEC      = 60,
  localparam int IDX_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1,
  localparam int DIV_W = $clog2(TICKS_PER_SEC)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_valid,
  input  logic [4:0]       set_hh,
  input  logic [5:0]       set_mm,
  input  logic [5:0]       set_ss,
  output logic             set_err,
  input  logic             alm_wr,
  input  logic [IDX_W-1:0] alm_idx,
  input  logic [4:0]       alm_hh,
  input  logic [5:0]       alm_mm,
  input  logic             alm_en,
  input  logic             snooze,
  input  logic             dismiss,
  output logic [4:0]       hh,
  output logic [5:0]       mm,
  output logic [5:0]       ss,
  output logic             sec_pulse,
  output logic             alarm_ring,
  output logic             alarm_snoozed,
  output logic [IDX_W-1:0] alarm_src
`ifdef RTC_HOUR12_EN
  ,
  output logic             pm
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RINGING,
    ST_SNOOZED
  } state_e;

  // ---------------------------------------------------------------------------
  // Seconds divider and time-of-day counters
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] div_q, div_d;
  logic [4:0]       hh_q, hh_d;
  logic [5:0]       mm_q, mm_d;
  logic [5:0]       ss_q, ss_d;
  logic             set_ok;
  logic             tick;
  logic             sec_adv;
  logic [4:0]       inc_hh;
  logic [5:0]       inc_mm;
  logic [5:0]       inc_ss;

  assign set_ok  = set_valid && (set_hh < 5'd24) && (set_mm < 6'd60) && (set_ss < 6'd60);
  assign tick    = (div_q == DIV_W'(TICKS_PER_SEC - 1));
  // A valid load overrides a coincident tick, so the second is not advanced.
  assign sec_adv = tick && !set_ok;
  assign sec_pulse = sec_adv;

  // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    inc_ss = ss_q + 6'd1;
    inc_mm = mm_q;
    inc_hh = hh_q;
    if (ss_q == 6'd59) begin
      inc_ss = 6'd0;
      inc_mm = mm_q + 6'd1;
      if (mm_q == 6'd59) begin
        inc_mm = 6'd0;
        inc_hh = (hh_q == 5'd23) ? 5'd0 : hh_q + 5'd1;
      end
    end
  end

  always_comb begin
    div_d = tick ? '0 : div_q + DIV_W'(1);
    hh_d  = hh_q;
    mm_d  = mm_q;
    ss_d  = ss_q;
    if (set_ok) begin
      div_d = '0;
      hh_d  = set_hh;
      mm_d  = set_mm;
      ss_d  = set_ss;
    end else if (tick) begin
      hh_d = inc_hh;
      mm_d = inc_mm;
      ss_d = inc_ss;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q <= '0;
      hh_q  <= '0;
      mm_q  <= '0;
      ss_q  <= '0;
    end else begin
      div_q <= div_d;
      hh_q  <= hh_d;
      mm_q  <= mm_d;
      ss_q  <= ss_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Alarm slots
  // ---------------------------------------------------------------------------
  logic [4:0]            slot_hh_q [NUM_ALARMS];
  logic [5:0]            slot_mm_q [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] slot_en_q;
  logic [31:0]           wr_idx;

  assign wr_idx = 32'(alm_idx);

  // NOTE: the slot array is small and architecturally visible after reset, so it is reset like ordinary flops rather than left as uninitialised RAM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        slot_hh_q[i] <= '0;
        slot_mm_q[i] <= '0;
      end
      slot_en_q <= '0;
    end else if (alm_wr && (wr_idx < 32'(NUM_ALARMS))) begin
      slot_hh_q[alm_idx] <= alm_hh;
      slot_mm_q[alm_idx] <= alm_mm;
      // An unreachable alarm time is stored but can never fire.
      slot_en_q[alm_idx] <= alm_en && (alm_hh < 5'd24) && (alm_mm < 6'd60);
    end
  end

  logic             match_hit;
  logic [IDX_W-1:0] match_idx;

  // Scan from the top so the lowest matching index is the one left standing.
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (slot_en_q[i] && (slot_hh_q[i] == inc_hh) && (slot_mm_q[i] == inc_mm)) begin
        match_hit = 1'b1;
        match_idx = IDX_W'(i);
      end
    end
    match_hit = match_hit && sec_adv && (inc_ss == 6'd0);
  end

  // ---------------------------------------------------------------------------
  // Snooze target: current hh:mm plus SNOOZE_MIN, wrapping at midnight
  // ---------------------------------------------------------------------------
  logic [6:0] snz_mm_sum;
  logic [4:0] snz_hh;
  logic [5:0] snz_mm;

  always_comb begin
    snz_mm_sum = {1'b0, mm_q} + 7'(SNOOZE_MIN);
    if (snz_mm_sum >= 7'd60) begin
      snz_mm = 6'(snz_mm_sum - 7'd60);
      snz_hh = (hh_q == 5'd23) ? 5'd0 : hh_q + 5'd1;
    end else begin
      snz_mm = snz_mm_sum[5:0];
      snz_hh = hh_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Ring / snooze / dismiss controller
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [7:0]       ring_cnt_q, ring_cnt_d;
  logic [IDX_W-1:0] src_q, src_d;
  logic [4:0]       tgt_hh_q, tgt_hh_d;
  logic [5:0]       tgt_mm_q, tgt_mm_d;
  logic             ring_done;
  logic             snooze_hit;
  logic             ring_q;
  logic             snoozed_q;
  logic             set_err_q;

  assign ring_done  = sec_adv && (({1'b0, ring_cnt_q} + 9'd1) == 9'(RING_SEC));
  assign snooze_hit = sec_adv && (inc_ss == 6'd0) && (inc_hh == tgt_hh_q) && (inc_mm == tgt_mm_q);

  always_comb begin
    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
    src_d      = src_q;
    tgt_hh_d   = tgt_hh_q;
    tgt_mm_d   = tgt_mm_q;
    case (state_q)
      ST_IDLE: begin
        if (match_hit) begin
          state_d    = ST_RINGING;
          src_d      = match_idx;
          ring_cnt_d = '0;
        end
      end
      ST_RINGING: begin
        if (dismiss) begin
          state_d = ST_IDLE;
        end else if (snooze) begin
          state_d  = ST_SNOOZED;
          tgt_hh_d = snz_hh;
          tgt_mm_d = snz_mm;
        end else if (ring_done) begin
          state_d = ST_IDLE;
        end else if (sec_adv) begin
          ring_cnt_d = ring_cnt_q + 8'd1;
        end
      end
      ST_SNOOZED: begin
        if (dismiss) begin
          state_d = ST_IDLE;
        end else if (snooze_hit) begin
          state_d    = ST_RINGING;
          ring_cnt_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      ring_cnt_q <= '0;
      src_q      <= '0;
      tgt_hh_q   <= '0;
      tgt_mm_q   <= '0;
      ring_q     <= 1'b0;
      snoozed_q  <= 1'b0;
      set_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ring_cnt_q <= ring_cnt_d;
      src_q      <= src_d;
      tgt_hh_q   <= tgt_hh_d;
      tgt_mm_q   <= tgt_mm_d;
      ring_q     <= (state_d == ST_RINGING);
      snoozed_q  <= (state_d == ST_SNOOZED);
      set_err_q  <= set_valid && !set_ok;
    end
  end

  assign alarm_ring    = ring_q;
  assign alarm_snoozed = snoozed_q;
  assign alarm_src     = src_q;
  assign set_err       = set_err_q;
  assign mm            = mm_q;
  assign ss            = ss_q;

`ifdef RTC_HOUR12_EN
  always_comb begin
    if (hh_q == 5'd0) begin
      hh = 5'd12;
      pm = 1'b0;
    end else if (hh_q < 5'd12) begin
      hh = hh_q;
      pm = 1'b0;
    end else if (hh_q == 5'd12) begin
      hh = 5'd12;
      pm = 1'b1;
    end else begin
      hh = hh_q - 5'd12;
      pm = 1'b1;
    end
  end
`else
  assign hh = hh_q;
`endif

endmodule

// File: tb/tb_rtc_multi_alarm_core.sv
// Bench for rtc_multi_alarm_core: directed scenarios plus randomized traffic checked
// against a seconds-of-day reference model.
`timescale 1ns/1ps
module tb_rtc_multi_alarm_core;
  localparam int TPS  = 4;
  localparam int NA   = 3;
  localparam int SNZ  = 5;
  localparam int RSEC = 3;
  localparam int S_IDLE = 0, S_RING = 1, S_SNZ = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       set_valid = 1'b0;
  logic [4:0] set_hh = '0;
  logic [5:0] set_mm = '0, set_ss = '0;
  logic       set_err;
  logic       alm_wr = 1'b0;
  logic [1:0] alm_idx = '0;
  logic [4:0] alm_hh = '0;
  logic [5:0] alm_mm = '0;
  logic       alm_en = 1'b0;
  logic       snooze = 1'b0, dismiss = 1'b0;
  logic [4:0] hh;
  logic [5:0] mm, ss;
  logic       sec_pulse, alarm_ring, alarm_snoozed;
  logic [1:0] alarm_src;
`ifdef RTC_HOUR12_EN
  logic       pm;
`endif

  always #5 clk = ~clk;

  rtc_multi_alarm_core #(
    .TICKS_PER_SEC(TPS), .NUM_ALARMS(NA), .SNOOZE_MIN(SNZ), .RING_SEC(RSEC)
  ) dut (
    .clk(clk), .rst(rst),
    .set_valid(set_valid), .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss), .set_err(set_err),
    .alm_wr(alm_wr), .alm_idx(alm_idx), .alm_hh(alm_hh), .alm_mm(alm_mm), .alm_en(alm_en),
    .snooze(snooze), .dismiss(dismiss),
    .hh(hh), .mm(mm), .ss(ss), .sec_pulse(sec_pulse),
    .alarm_ring(alarm_ring), .alarm_snoozed(alarm_snoozed), .alarm_src(alarm_src)
`ifdef RTC_HOUR12_EN
    , .pm(pm)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: time kept as seconds of day, snooze target as minute of day.
  int m_tod, m_div, m_state, m_src, m_ring, m_target;
  bit m_err;
  int m_ahh [NA];
  int m_amm [NA];
  bit m_en  [NA];
  bit obs_pulse, obs_err, exp_pulse;

  function automatic int exp_hh(int h);
`ifdef RTC_HOUR12_EN
    if (h == 0) return 12;
    if (h > 12) return h - 12;
    return h;
`else
    return h;
`endif
  endfunction

  function automatic bit set_in_range();
    return set_valid && (set_hh < 24) && (set_mm < 60) && (set_ss < 60);
  endfunction

  task automatic model_reset();
    m_tod = 0; m_div = 0; m_state = S_IDLE; m_src = 0; m_ring = 0; m_target = 0; m_err = 0;
    for (int i = 0; i < NA; i++) begin
      m_ahh[i] = 0; m_amm[i] = 0; m_en[i] = 0;
    end
  endtask

  task automatic model_advance();
    bit ok, adv;
    int nt, cur_min, hit;
    ok = set_in_range();
    adv = (m_div == TPS - 1) && !ok;
    nt = m_tod;
    cur_min = m_tod / 60;
    if (ok) begin
      nt = int'(set_hh) * 3600 + int'(set_mm) * 60 + int'(set_ss);
      m_div = 0;
    end else begin
      m_div = (m_div + 1) % TPS;
      if (adv) nt = (m_tod + 1) % 86400;
    end
    case (m_state)
      S_IDLE: if (adv && (nt % 60 == 0)) begin
        hit = -1;
        for (int i = 0; i < NA; i++)
          if (hit < 0 && m_en[i] && (m_ahh[i] * 60 + m_amm[i] == nt / 60)) hit = i;
        if (hit >= 0) begin m_state = S_RING; m_src = hit; m_ring = 0; end
      end
      S_RING: begin
        if (dismiss) m_state = S_IDLE;
        else if (snooze) begin m_state = S_SNZ; m_target = (cur_min + SNZ) % 1440; end
        else if (adv) begin
          m_ring++;
          if (m_ring == RSEC) m_state = S_IDLE;
        end
      end
      S_SNZ: begin
        if (dismiss) m_state = S_IDLE;
        else if (adv && (nt == m_target * 60)) begin m_state = S_RING; m_ring = 0; end
      end
      default: ;
    endcase
    if (alm_wr && int'(alm_idx) < NA) begin
      m_ahh[alm_idx] = int'(alm_hh);
      m_amm[alm_idx] = int'(alm_mm);
      m_en[alm_idx]  = alm_en && (alm_hh < 24) && (alm_mm < 60);
    end
    m_err = set_valid && !ok;
    m_tod = nt;
  endtask

  // One clock: sample combinational/registered outputs at negedge, step the model at posedge.
  task automatic clk_cycle();
    @(negedge clk);
    obs_pulse = sec_pulse;
    obs_err   = set_err;
    exp_pulse = (m_div == TPS - 1) && !set_in_range();
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic load_time(int h, int m, int s);
    set_valid = 1'b1; set_hh = 5'(h); set_mm = 6'(m); set_ss = 6'(s);
    clk_cycle();
    set_valid = 1'b0;
  endtask

  task automatic write_slot(int idx, int h, int m, bit en);
    alm_wr = 1'b1; alm_idx = 2'(idx); alm_hh = 5'(h); alm_mm = 6'(m); alm_en = en;
    clk_cycle();
    alm_wr = 1'b0;
  endtask

  task automatic test_reset();
    int pulses;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (hh !== 5'(exp_hh(0))) begin n_fail++; $display("FAIL reset_hh: got %0d want %0d", hh, exp_hh(0)); end
    n_checks++;
    if ({mm, ss, sec_pulse, set_err, alarm_ring, alarm_snoozed, alarm_src} !== 18'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %h want 0", {mm, ss, sec_pulse, set_err, alarm_ring, alarm_snoozed, alarm_src});
    end
    rst = 1'b1;
    model_reset();
    pulses = 0;
    repeat (16) begin
      clk_cycle();
      pulses += int'(obs_pulse);
    end
    n_checks++;
    if (ss !== 6'd4) begin n_fail++; $display("FAIL run16_ss: got %0d want 4", ss); end
    n_checks++;
    if (pulses != 4) begin n_fail++; $display("FAIL run16_pulses: got %0d want 4", pulses); end
    repeat (2) clk_cycle();
    rst = 1'b0;
    #1;
    n_checks++;
    if (hh !== 5'(exp_hh(0)) || {mm, ss, sec_pulse, set_err, alarm_ring, alarm_snoozed, alarm_src} !== 18'd0) begin
      n_fail++; $display("FAIL midcount_reset: got hh=%0d mm=%0d ss=%0d pulse=%b want all zero", hh, mm, ss, sec_pulse);
    end
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_rollover();
    load_time(23, 59, 58);
    n_checks++;
    if (hh !== 5'(exp_hh(23)) || mm !== 6'd59 || ss !== 6'd58) begin
      n_fail++; $display("FAIL load_235958: got %0d:%0d:%0d", hh, mm, ss);
    end
    repeat (4) clk_cycle();
    n_checks++;
    if (hh !== 5'(exp_hh(23)) || mm !== 6'd59 || ss !== 6'd59) begin
      n_fail++; $display("FAIL tick_235959: got %0d:%0d:%0d", hh, mm, ss);
    end
    repeat (4) clk_cycle();
    n_checks++;
    if (hh !== 5'(exp_hh(0)) || mm !== 6'd0 || ss !== 6'd0) begin
      n_fail++; $display("FAIL rollover_000000: got %0d:%0d:%0d want 0:0:0", hh, mm, ss);
    end
  endtask

  task automatic test_set_err();
    int errs;
    load_time(10, 60, 0);
    errs = int'(obs_err);
    repeat (3) begin
      clk_cycle();
      errs += int'(obs_err);
    end
    n_checks++;
    if (errs != 1) begin n_fail++; $display("FAIL set_err_pulses: got %0d want 1", errs); end
    n_checks++;
    if (hh !== 5'(exp_hh(0)) || mm !== 6'd0 || ss !== 6'd1) begin
      n_fail++; $display("FAIL set_err_time: got %0d:%0d:%0d want 0:0:1", hh, mm, ss);
    end
  endtask

  task automatic test_set_on_tick();
    for (int k = 0; k < 8 && m_div != TPS - 1; k++) clk_cycle();
    n_checks++;
    if (m_div != TPS - 1) begin n_fail++; $display("FAIL set_tick_align: got div %0d want %0d", m_div, TPS - 1); end
    load_time(12, 34, 56);
    n_checks++;
    if (obs_pulse !== 1'b0) begin n_fail++; $display("FAIL set_tick_pulse: got %b want 0", obs_pulse); end
    n_checks++;
    if (hh !== 5'(exp_hh(12)) || mm !== 6'd34 || ss !== 6'd56) begin
      n_fail++; $display("FAIL set_tick_time: got %0d:%0d:%0d want 12:34:56", hh, mm, ss);
    end
    repeat (3) clk_cycle();
    n_checks++;
    if (ss !== 6'd56) begin n_fail++; $display("FAIL set_tick_divclr: got ss %0d want 56", ss); end
    clk_cycle();
    n_checks++;
    if (ss !== 6'd57 || obs_pulse !== 1'b1) begin
      n_fail++; $display("FAIL set_tick_next: got ss %0d pulse %b want 57 1", ss, obs_pulse);
    end
  endtask

  task automatic test_alarm_priority();
    write_slot(0, 7, 31, 1'b1);
    write_slot(1, 7, 30, 1'b1);
    write_slot(2, 7, 30, 1'b1);
    load_time(7, 29, 59);
    repeat (4) clk_cycle();
    n_checks++;
    if (alarm_ring !== 1'b1 || alarm_src !== 2'd1 || alarm_snoozed !== 1'b0) begin
      n_fail++; $display("FAIL prio_ring: got ring %b src %0d snz %b want 1 1 0", alarm_ring, alarm_src, alarm_snoozed);
    end
    n_checks++;
    if (hh !== 5'(exp_hh(7)) || mm !== 6'd30 || ss !== 6'd0) begin
      n_fail++; $display("FAIL prio_time: got %0d:%0d:%0d want 7:30:0", hh, mm, ss);
    end
    write_slot(1, 7, 30, 1'b0);
    repeat (7) clk_cycle();
    n_checks++;
    if (alarm_ring !== 1'b1 || alarm_src !== 2'd1) begin
      n_fail++; $display("FAIL ring_hold: got ring %b src %0d want 1 1", alarm_ring, alarm_src);
    end
    repeat (4) clk_cycle();
    n_checks++;
    if (alarm_ring !== 1'b0 || alarm_snoozed !== 1'b0) begin
      n_fail++; $display("FAIL ring_expire: got ring %b snz %b want 0 0", alarm_ring, alarm_snoozed);
    end
  endtask

  task automatic test_snooze();
    bit rang;
    load_time(7, 29, 59);
    repeat (4) clk_cycle();
    n_checks++;
    if (alarm_ring !== 1'b1 || alarm_src !== 2'd2) begin
      n_fail++; $display("FAIL snz_first_ring: got ring %b src %0d want 1 2", alarm_ring, alarm_src);
    end
    snooze = 1'b1;
    clk_cycle();
    snooze = 1'b0;
    n_checks++;
    if (alarm_snoozed !== 1'b1 || alarm_ring !== 1'b0) begin
      n_fail++; $display("FAIL snz_enter: got snz %b ring %b want 1 0", alarm_snoozed, alarm_ring);
    end
    rang = 1'b0;
    for (int k = 0; k < 1400 && !rang; k++) begin
      clk_cycle();
      rang = alarm_ring;
    end
    n_checks++;
    if (!rang) begin n_fail++; $display("FAIL snz_rering_timeout: got no ring within 1400 cycles want ring"); end
    n_checks++;
    if (hh !== 5'(exp_hh(7)) || mm !== 6'd35 || ss !== 6'd0 || alarm_src !== 2'd2) begin
      n_fail++; $display("FAIL snz_rering_time: got %0d:%0d:%0d src %0d want 7:35:0 src 2", hh, mm, ss, alarm_src);
    end
    dismiss = 1'b1; snooze = 1'b1;
    clk_cycle();
    dismiss = 1'b0; snooze = 1'b0;
    n_checks++;
    if (alarm_ring !== 1'b0 || alarm_snoozed !== 1'b0) begin
      n_fail++; $display("FAIL dismiss_wins: got ring %b snz %b want 0 0", alarm_ring, alarm_snoozed);
    end
  endtask

  task automatic test_snooze_wrap();
    write_slot(0, 23, 58, 1'b1);
    load_time(23, 57, 59);
    repeat (4) clk_cycle();
    n_checks++;
    if (alarm_ring !== 1'b1 || alarm_src !== 2'd0) begin
      n_fail++; $display("FAIL wrap_ring: got ring %b src %0d want 1 0", alarm_ring, alarm_src);
    end
    snooze = 1'b1;
    clk_cycle();
    snooze = 1'b0;
    load_time(0, 2, 59);
    n_checks++;
    if (alarm_snoozed !== 1'b1) begin n_fail++; $display("FAIL wrap_set_keeps_snooze: got %b want 1", alarm_snoozed); end
    repeat (4) clk_cycle();
    n_checks++;
    if (alarm_ring !== 1'b1 || alarm_src !== 2'd0 || hh !== 5'(exp_hh(0)) || mm !== 6'd3 || ss !== 6'd0) begin
      n_fail++; $display("FAIL wrap_rering: got ring %b src %0d %0d:%0d:%0d want 1 0 0:3:0", alarm_ring, alarm_src, hh, mm, ss);
    end
    dismiss = 1'b1;
    clk_cycle();
    dismiss = 1'b0;
    n_checks++;
    if (alarm_ring !== 1'b0 || alarm_snoozed !== 1'b0) begin
      n_fail++; $display("FAIL wrap_dismiss: got ring %b snz %b want 0 0", alarm_ring, alarm_snoozed);
    end
  endtask

`ifdef RTC_HOUR12_EN
  task automatic test_hour12();
    load_time(0, 15, 0);
    n_checks++;
    if (hh !== 5'd12 || pm !== 1'b0) begin n_fail++; $display("FAIL h12_midnight: got %0d pm %b want 12 0", hh, pm); end
    load_time(13, 0, 0);
    n_checks++;
    if (hh !== 5'd1 || pm !== 1'b1) begin n_fail++; $display("FAIL h12_1pm: got %0d pm %b want 1 1", hh, pm); end
  endtask
`endif

  task automatic test_random();
    int mn;
    for (int c = 0; c < 3000; c++) begin
      set_valid = ($urandom_range(0, 39) == 0);
      if (set_valid) begin
        set_hh = 5'($urandom_range(0, 23));
        set_mm = 6'($urandom_range(0, 59));
        set_ss = 6'($urandom_range(50, 59));
        case ($urandom_range(0, 7))
          0: set_hh = 5'($urandom_range(24, 31));
          1: set_mm = 6'($urandom_range(60, 63));
          2: set_ss = 6'($urandom_range(60, 63));
          default: ;
        endcase
      end
      alm_wr = ($urandom_range(0, 19) == 0);
      if (alm_wr) begin
        mn = (m_tod / 60 + int'($urandom_range(0, 1))) % 1440;
        alm_idx = 2'($urandom_range(0, 3));
        alm_hh  = 5'(mn / 60);
        alm_mm  = 6'(mn % 60);
        alm_en  = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 7) == 0) alm_mm = 6'($urandom_range(60, 63));
      end
      snooze  = ($urandom_range(0, 39) == 0);
      dismiss = ($urandom_range(0, 59) == 0);
      clk_cycle();
      n_checks++;
      if (hh !== 5'(exp_hh(m_tod / 3600)) || mm !== 6'((m_tod / 60) % 60) || ss !== 6'(m_tod % 60)) begin
        n_fail++; $display("FAIL rnd_time c=%0d: got %0d:%0d:%0d want tod %0d", c, hh, mm, ss, m_tod);
      end
      n_checks++;
      if (obs_pulse !== exp_pulse) begin n_fail++; $display("FAIL rnd_pulse c=%0d: got %b want %b", c, obs_pulse, exp_pulse); end
      n_checks++;
      if (set_err !== m_err) begin n_fail++; $display("FAIL rnd_set_err c=%0d: got %b want %b", c, set_err, m_err); end
      n_checks++;
      if (alarm_ring !== (m_state == S_RING) || alarm_snoozed !== (m_state == S_SNZ)) begin
        n_fail++; $display("FAIL rnd_state c=%0d: got ring %b snz %b want state %0d", c, alarm_ring, alarm_snoozed, m_state);
      end
      if (m_state != S_IDLE) begin
        n_checks++;
        if (alarm_src !== 2'(m_src)) begin n_fail++; $display("FAIL rnd_src c=%0d: got %0d want %0d", c, alarm_src, m_src); end
      end
`ifdef RTC_HOUR12_EN
      n_checks++;
      if (pm !== (m_tod >= 12 * 3600)) begin n_fail++; $display("FAIL rnd_pm c=%0d: got %b want %b", c, pm, m_tod >= 12 * 3600); end
`endif
    end
    set_valid = 1'b0; alm_wr = 1'b0; snooze = 1'b0; dismiss = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rollover();
    test_set_err();
    test_set_on_tick();
    test_alarm_priority();
    test_snooze();
    test_snooze_wrap();
`ifdef RTC_HOUR12_EN
    test_hour12();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation time limit want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
